hwpf_issue_arbiter: RTL and testbench
=====================================

Name: hwpf_issue_arbiter

Overview:
- Shares the single L1 data-cache request port between CPU demand requests and next-line prefetch requests popped from hwpf_fifo.
- Demand traffic has priority. Prefetches issue when the port is free, subject to an in-flight credit limit and an anti-starvation boost.
- Drives the FIFO's read, flush and lock controls, so it sits between the prefetch FIFO, the CPU LSU and the dcache request arbiter.

Parameters:
- PF_CREDITS, 4: maximum prefetches accepted by the dcache and not yet answered (1..15).
- STARVE_LIMIT, 16: consecutive cycles a pending prefetch may lose before it is boosted (2..255).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- cpu_req_valid_i  in  1  demand request valid
- cpu_req_i  in  req_cpu_dcache_t  demand request
- cpu_req_ready_o  out  1  demand request accepted this cycle
- pf_req_valid_i  in  1  FIFO head valid (hwpf_fifo arbiter_req_valid_o)
- pf_req_i  in  req_cpu_dcache_t  FIFO head (hwpf_fifo arbiter_req_o)
- pf_read_o  out  1  pop FIFO head (to hwpf_fifo read_i)
- pf_flush_o  out  1  FIFO flush (to hwpf_fifo flush_i)
- pf_lock_o  out  1  FIFO enable/lock (to hwpf_fifo lock_i)
- pf_enable_i  in  1  prefetcher globally enabled
- kill_i  in  1  pipeline flush / context switch
- dc_req_valid_o  out  1  request to dcache valid
- dc_req_o  out  req_cpu_dcache_t  request to dcache
- dc_req_is_pf_o  out  1  held request is a prefetch
- dc_req_ready_i  in  1  dcache accepts the held request
- pf_rsp_valid_i  in  1  one prefetch response returned (releases one credit)
- pf_credits_o  out  $clog2(PF_CREDITS+1)  prefetch credits in use

Behaviour:
- Reset values: all outputs 0; FSM state IDLE; starve counter 0; credit counter 0. Reset asserted mid-transaction drops the held request.
- Output stage is a one-entry register. Grant in cycle N gives dc_req_valid_o=1 in cycle N+1.
- dc_req_o and dc_req_is_pf_o hold stable while dc_req_valid_o && !dc_req_ready_i.
- FSM states:
  - IDLE: output register empty.
  - HOLD: output register full.
  - FLUSH: one cycle.
- Grantable in cycle N when state==IDLE, or state==HOLD && dc_req_ready_i (back-to-back issue, no bubble).
- Grant rule when grantable:
  - pf_ok = pf_req_valid_i && pf_enable_i && credits<PF_CREDITS && state!=FLUSH.
  - If starve==STARVE_LIMIT and pf_ok, grant the prefetch.
  - Otherwise grant the CPU if cpu_req_valid_i, else the prefetch if pf_ok.
- cpu_req_ready_o=1 only in the cycle the CPU is granted (combinational from dc_req_ready_i). pf_read_o=1 only in the cycle a prefetch is granted.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle pf_ok && the prefetch is not granted.
  - Clears on a prefetch grant or when !pf_ok.
- Credits:
  - Increment when dc_req_valid_o && dc_req_ready_i && dc_req_is_pf_o.
  - Decrement on pf_rsp_valid_i.
  - Both in the same cycle: unchanged.
  - Saturate at 0 and PF_CREDITS; a decrement at 0 is ignored.
- pf_lock_o = pf_enable_i registered, 1-cycle delay.
- kill_i behaviour:
  - pf_flush_o=1 for exactly one cycle, next state FLUSH, and no prefetch grant that cycle or the next.
  - A held demand request stays until accepted.
  - A held prefetch is dropped: the output register clears, no credit is taken, and a FLUSH→IDLE transition follows.
  - Credits are not reset, because outstanding responses still return.
- FLUSH→IDLE next cycle, or FLUSH→HOLD if a CPU grant occurs in FLUSH (CPU grants are allowed).
- Simultaneous kill_i and prefetch grant: kill wins, no pop.

Optional Feature:
- HWPF_ARB_STATS_EN defined: adds output ports pf_issued_cnt_o [31:0], pf_starve_boost_cnt_o [31:0] and pf_killed_cnt_o [31:0]. These are wrapping counters of accepted prefetches, boosted grants and dropped held prefetches; all reset to 0.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package hwpf_pkg holds:
  - arb_state_t (IDLE, HOLD, FLUSH);
  - HWPF_PF_CREDITS_DEF and HWPF_STARVE_LIMIT_DEF;
  - the credit-width function.
- req_cpu_dcache_t stays in drac_pkg.
- One natural sub-module: hwpf_credit_counter (up/down saturating counter with simultaneous inc/dec). The stats counters instantiate a plain wrapping counter inline.

Test Plan:
- CPU valid rd=1, data_rs1=0xCAFECAFE, FIFO empty, dc ready=1 → cpu_req_ready_o=1 in cycle N; dc_req_valid_o=1, dc_req_o.rd=1, is_pf=0 in N+1.
- CPU and prefetch valid every cycle, STARVE_LIMIT=4 → CPU granted 4 cycles, prefetch granted 5th with pf_read_o=1, starve counter back to 0.
- PF_CREDITS=2, three prefetches accepted, no responses → third not granted (pf_read_o=0), pf_credits_o=2. One pf_rsp_valid_i → third issues next grant.
- Held prefetch with dc_req_ready_i=0, kill_i pulse → pf_flush_o=1 one cycle, dc_req_valid_o=0 next cycle, credits unchanged, no pop for 2 cycles.
- Prefetch accepted and pf_rsp_valid_i in same cycle at credits=1 → credits stay 1. Reset asserted while in HOLD → all outputs 0 immediately.
- pf_enable_i=0 with FIFO valid → pf_read_o never asserts, pf_lock_o=0 one cycle after the drop.

Source files
------------

// File: rtl/drac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drac_pkg
//  Description : Core-wide request type shared by the LSU, the prefetcher and
//                the dcache request path.
//  Revision    : 1.0 - initial release
// ============================================================================
package drac_pkg;

    // Request presented to the L1 data cache port
    typedef struct packed {
        logic        valid;
        logic [63:0] data_rs1;
        logic [63:0] data_rs2;
        logic [4:0]  rd;
        logic [3:0]  instr_type;
        logic [2:0]  mem_size;
        logic [63:0] imm;
    } req_cpu_dcache_t;

endpackage : drac_pkg
`default_nettype wire

// File: rtl/hwpf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hwpf_pkg
//  Description : Shared types and defaults for the hardware prefetcher issue
//                path (arbiter state encoding, default limits, width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package hwpf_pkg;

    // Default maximum number of prefetches in flight at the dcache
    localparam int unsigned HWPF_PF_CREDITS_DEF   = 4;
    // Default number of lost arbitration cycles before a prefetch is boosted
    localparam int unsigned HWPF_STARVE_LIMIT_DEF = 16;

    // Issue arbiter state: IDLE = output register empty, HOLD = full,
    // FLUSH = single cycle following a kill
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HOLD  = 2'd1,
        ARB_FLUSH = 2'd2
    } arb_state_t;

    // Bits needed to count 0..max_credits inclusive
    function automatic int unsigned hwpf_credit_width(input int unsigned max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage : hwpf_pkg
`default_nettype wire

// File: rtl/hwpf_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hwpf_credit_counter
//  Description : Up/down counter saturating at 0 and MAX_COUNT. Simultaneous
//                increment and decrement leave the count unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwpf_credit_counter #(
    parameter int unsigned MAX_COUNT = 4,
    parameter int unsigned WIDTH     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MAX_COUNT);

    // Saturating count update; an increment at the top or a decrement at
    // zero is dropped rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && (count != COUNT_MAX)) begin
            count <= count + WIDTH'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule : hwpf_credit_counter
`default_nettype wire

// File: rtl/hwpf_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hwpf_issue_arbiter
//  Description : Shares the L1 dcache request port between CPU demand
//                requests and next-line prefetches from hwpf_fifo. Demand has
//                priority; prefetches are limited by in-flight credits and
//                boosted after STARVE_LIMIT lost cycles. One-entry output
//                register. Optional statistics counters are enabled with the
//                HWPF_ARB_STATS_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwpf_issue_arbiter
    import drac_pkg::*;
    import hwpf_pkg::*;
#(
    parameter int unsigned PF_CREDITS   = HWPF_PF_CREDITS_DEF,
    parameter int unsigned STARVE_LIMIT = HWPF_STARVE_LIMIT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cpu_req_valid_i,
    input  req_cpu_dcache_t cpu_req_i,
    output logic            cpu_req_ready_o,
    input  logic            pf_req_valid_i,
    input  req_cpu_dcache_t pf_req_i,
    output logic            pf_read_o,
    output logic            pf_flush_o,
    output logic            pf_lock_o,
    input  logic            pf_enable_i,
    input  logic            kill_i,
    output logic            dc_req_valid_o,
    output req_cpu_dcache_t dc_req_o,
    output logic            dc_req_is_pf_o,
    input  logic            dc_req_ready_i,
    input  logic            pf_rsp_valid_i,
    output logic [hwpf_credit_width(PF_CREDITS)-1:0] pf_credits_o
`ifdef HWPF_ARB_STATS_EN
    ,
    output logic [31:0]     pf_issued_cnt_o,
    output logic [31:0]     pf_starve_boost_cnt_o,
    output logic [31:0]     pf_killed_cnt_o
`endif
);

    localparam int unsigned     CW         = hwpf_credit_width(PF_CREDITS);
    localparam int unsigned     SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(PF_CREDITS);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t      state;
    arb_state_t      state_next;

    logic            out_valid;
    req_cpu_dcache_t out_req;
    logic            out_is_pf;
    logic            lock;
    logic [SW-1:0]   starve;
    logic [CW-1:0]   credits;

    logic            handshake;
    logic            pf_accept;
    logic            drop_pf;
    logic            grantable;
    logic            pf_ok;
    logic            boost;
    logic            pf_sel;
    logic            pf_grant;
    logic            cpu_grant;
    logic            any_grant;
    logic            out_full_next;

    // ------------------------------------------------------------------
    // Grant decode
    // ------------------------------------------------------------------
    assign handshake = out_valid && dc_req_ready_i;
    assign pf_accept = handshake && out_is_pf;

    // A kill discards a held prefetch the dcache has not taken this cycle.
    // If the dcache takes it in the kill cycle it is already issued and its
    // response will come back, so it is counted as a normal acceptance.
    assign drop_pf   = kill_i && out_valid && out_is_pf && !dc_req_ready_i;

    // The register can be reloaded when empty or being drained this cycle
    assign grantable = !out_valid || dc_req_ready_i;

    assign pf_ok     = pf_req_valid_i && pf_enable_i &&
                       (credits < CREDIT_MAX) && (state != ARB_FLUSH);
    assign boost     = pf_ok && (starve == STARVE_MAX);
    assign pf_sel    = boost || (pf_ok && !cpu_req_valid_i);

    // Kill suppresses the prefetch pop; a waiting demand may take the slot
    assign pf_grant  = grantable && pf_sel && !kill_i;
    assign cpu_grant = grantable && cpu_req_valid_i && !pf_grant;
    assign any_grant = pf_grant || cpu_grant;

    // Register occupancy after this cycle
    assign out_full_next = any_grant ||
                           (out_valid && !dc_req_ready_i && !drop_pf);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: kill always lands in FLUSH, otherwise track occupancy
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (kill_i)             state_next = ARB_FLUSH;
                else if (out_full_next) state_next = ARB_HOLD;
                else                    state_next = ARB_IDLE;
            end
            ARB_HOLD: begin
                if (kill_i)             state_next = ARB_FLUSH;
                else if (out_full_next) state_next = ARB_HOLD;
                else                    state_next = ARB_IDLE;
            end
            ARB_FLUSH: begin
                // A demand granted here, or a demand still held, keeps HOLD
                if (kill_i)             state_next = ARB_FLUSH;
                else if (out_full_next) state_next = ARB_HOLD;
                else                    state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // FSM outputs to the LSU and FIFO, forced low while reset is asserted
    always_comb begin
        cpu_req_ready_o = rst_ni && cpu_grant;
        pf_read_o       = rst_ni && pf_grant;
        pf_flush_o      = rst_ni && kill_i;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // One-entry output register: load on grant, clear on drain or drop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_req   <= '0;
            out_is_pf <= 1'b0;
        end else if (any_grant) begin
            out_valid <= 1'b1;
            out_req   <= pf_grant ? pf_req_i : cpu_req_i;
            out_is_pf <= pf_grant;
        end else if (handshake || drop_pf) begin
            out_valid <= 1'b0;
            out_req   <= '0;
            out_is_pf <= 1'b0;
        end
    end

    // Starvation counter: counts cycles an eligible prefetch loses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve <= '0;
        end else if (pf_ok && !pf_grant) begin
            if (starve != STARVE_MAX) begin
                starve <= starve + SW'(1);
            end
        end else begin
            starve <= '0;
        end
    end

    // FIFO lock follows the global enable one cycle later
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock <= 1'b0;
        end else begin
            lock <= pf_enable_i;
        end
    end

    // In-flight prefetch credits; kill leaves these alone because the
    // outstanding responses still return
    hwpf_credit_counter #(
        .MAX_COUNT (PF_CREDITS),
        .WIDTH     (CW)
    ) u_credit_counter (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (pf_accept),
        .dec   (pf_rsp_valid_i),
        .count (credits)
    );

    assign dc_req_valid_o = out_valid;
    assign dc_req_o       = out_req;
    assign dc_req_is_pf_o = out_is_pf;
    assign pf_lock_o      = lock;
    assign pf_credits_o   = credits;

`ifdef HWPF_ARB_STATS_EN
    logic [31:0] issued_cnt;
    logic [31:0] boost_cnt;
    logic [31:0] killed_cnt;

    // Wrapping event counters: accepted prefetches, boosted grants, drops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_cnt <= 32'd0;
            boost_cnt  <= 32'd0;
            killed_cnt <= 32'd0;
        end else begin
            if (pf_accept)          issued_cnt <= issued_cnt + 32'd1;
            if (pf_grant && boost)  boost_cnt  <= boost_cnt + 32'd1;
            if (drop_pf)            killed_cnt <= killed_cnt + 32'd1;
        end
    end

    assign pf_issued_cnt_o       = issued_cnt;
    assign pf_starve_boost_cnt_o = boost_cnt;
    assign pf_killed_cnt_o       = killed_cnt;
`endif

endmodule : hwpf_issue_arbiter
`default_nettype wire

// File: tb/tb_hwpf_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hwpf_issue_arbiter
//  Description : Directed, table-driven bench for hwpf_issue_arbiter built
//                with PF_CREDITS=2 and STARVE_LIMIT=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpf_issue_arbiter;
    import drac_pkg::*;

    localparam int unsigned PF_CREDITS   = 2;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam logic [63:0] CPU_ADDR     = 64'h0000_0000_CAFE_CAFE;
    localparam logic [63:0] PF_ADDR      = 64'h0000_0000_0000_1040;
    localparam logic [4:0]  PF_RD        = 5'd7;
    localparam int          NV           = 44;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cpu_v;
    req_cpu_dcache_t cpu_req;
    logic            cpu_ready;
    logic            pf_v;
    req_cpu_dcache_t pf_req;
    logic            pf_read;
    logic            pf_flush;
    logic            pf_lock;
    logic            en;
    logic            kill;
    logic            dc_v;
    req_cpu_dcache_t dc_req;
    logic            dc_is_pf;
    logic            dc_rdy;
    logic            rsp;
    logic [1:0]      credits;
`ifdef HWPF_ARB_STATS_EN
    logic [31:0]     st_issued;
    logic [31:0]     st_boost;
    logic [31:0]     st_killed;
`endif

    int n_pass  = 0;
    int n_total = 0;

    hwpf_issue_arbiter #(
        .PF_CREDITS   (PF_CREDITS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cpu_req_valid_i (cpu_v),
        .cpu_req_i       (cpu_req),
        .cpu_req_ready_o (cpu_ready),
        .pf_req_valid_i  (pf_v),
        .pf_req_i        (pf_req),
        .pf_read_o       (pf_read),
        .pf_flush_o      (pf_flush),
        .pf_lock_o       (pf_lock),
        .pf_enable_i     (en),
        .kill_i          (kill),
        .dc_req_valid_o  (dc_v),
        .dc_req_o        (dc_req),
        .dc_req_is_pf_o  (dc_is_pf),
        .dc_req_ready_i  (dc_rdy),
        .pf_rsp_valid_i  (rsp),
        .pf_credits_o    (credits)
`ifdef HWPF_ARB_STATS_EN
        ,
        .pf_issued_cnt_o       (st_issued),
        .pf_starve_boost_cnt_o (st_boost),
        .pf_killed_cnt_o       (st_killed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cpu_v;
        logic [4:0] cpu_rd;
        logic       pf_v;
        logic       en;
        logic       kill;
        logic       rdy;
        logic       rsp;
        logic       e_cpu_rdy;
        logic       e_pf_read;
        logic       e_flush;
        logic       e_dc_v;
        logic [4:0] e_rd;
        logic       e_is_pf;
        logic [1:0] e_cr;
        logic       e_lock;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic cv, input logic [4:0] crd, input logic pv,
                                input logic e, input logic k, input logic r, input logic rs,
                                input logic ecr, input logic epr, input logic efl,
                                input logic edv, input logic [4:0] erd, input logic eip,
                                input logic [1:0] ecc, input logic elk);
        vec_t v;
        v.cpu_v = cv;  v.cpu_rd = crd; v.pf_v = pv; v.en = e; v.kill = k;
        v.rdy = r;     v.rsp = rs;
        v.e_cpu_rdy = ecr; v.e_pf_read = epr; v.e_flush = efl; v.e_dc_v = edv;
        v.e_rd = erd;  v.e_is_pf = eip; v.e_cr = ecc; v.e_lock = elk;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL v%0d %s got 0x%0h expected 0x%0h", idx, name, got, exp);
    endtask

    task automatic check_all_zero(input int idx);
        check("rst cpu_ready", idx, 64'(cpu_ready), 64'd0);
        check("rst pf_read",   idx, 64'(pf_read),   64'd0);
        check("rst pf_flush",  idx, 64'(pf_flush),  64'd0);
        check("rst pf_lock",   idx, 64'(pf_lock),   64'd0);
        check("rst dc_valid",  idx, 64'(dc_v),      64'd0);
        check("rst dc_is_pf",  idx, 64'(dc_is_pf),  64'd0);
        check("rst dc_req",    idx, 64'(dc_req.data_rs1 | 64'(dc_req.rd)), 64'd0);
        check("rst credits",   idx, 64'(credits),   64'd0);
    endtask

    initial begin
        //         cv crd pv en k  r  rs | crdy prd fl dv rd  pf cr lk
        // single demand request
        vecs[0]  = mk(1, 1, 0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        // demand and prefetch both valid: boost after four losses, twice
        vecs[3]  = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 1);
        vecs[4]  = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 0, 1);
        vecs[5]  = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 0, 1);
        vecs[6]  = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 0, 1);
        vecs[7]  = mk(1, 2, 1, 1, 0, 1, 0,  0, 1, 0, 1, 2, 0, 0, 1);
        vecs[8]  = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 1, 7, 1, 0, 1);
        vecs[9]  = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 1, 1);
        vecs[10] = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 1, 1);
        vecs[11] = mk(1, 2, 1, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 1, 1);
        vecs[12] = mk(1, 2, 1, 1, 0, 1, 0,  0, 1, 0, 1, 2, 0, 1, 1);
        vecs[13] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 7, 1, 1, 1);
        // credits exhausted, then released by a response
        vecs[14] = mk(0, 0, 1, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 2, 1);
        vecs[15] = mk(0, 0, 1, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 2, 1);
        vecs[16] = mk(0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0, 0, 1, 1);
        // acceptance and response in the same cycle at credits=1
        vecs[17] = mk(0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 1, 7, 1, 1, 1);
        vecs[18] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        // kill while a prefetch is held
        vecs[19] = mk(0, 0, 1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1);
        vecs[20] = mk(0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 1, 7, 1, 1, 1);
        vecs[21] = mk(0, 0, 1, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        vecs[22] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        // kill while a demand is held: it stays until accepted
        vecs[23] = mk(1, 3, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 1);
        vecs[24] = mk(0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 1, 3, 0, 1, 1);
        vecs[25] = mk(1, 4, 0, 1, 0, 0, 0,  0, 0, 0, 1, 3, 0, 1, 1);
        vecs[26] = mk(1, 4, 0, 1, 0, 1, 0,  1, 0, 0, 1, 3, 0, 1, 1);
        vecs[27] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 4, 0, 1, 1);
        // response drains credits to zero; a response at zero is ignored
        vecs[28] = mk(0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 1);
        vecs[29] = mk(0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1);
        vecs[30] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        // demand granted in FLUSH, prefetch blocked there
        vecs[31] = mk(0, 0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 0, 0, 0, 1);
        vecs[32] = mk(1, 5, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 1);
        vecs[33] = mk(0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 1, 5, 0, 0, 1);
        vecs[34] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 7, 1, 0, 1);
        vecs[35] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        // kill coinciding with a would-be prefetch grant: no pop for 2 cycles
        vecs[36] = mk(0, 0, 1, 1, 1, 1, 0,  0, 0, 1, 0, 0, 0, 1, 1);
        vecs[37] = mk(0, 0, 1, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        vecs[38] = mk(0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0, 0, 1, 1);
        vecs[39] = mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 7, 1, 1, 1);
        vecs[40] = mk(0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 2, 1);
        // prefetcher disabled with FIFO valid
        vecs[41] = mk(0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        vecs[42] = mk(0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[43] = mk(0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);

        rst_n   = 1'b0;
        cpu_v   = 1'b0;
        pf_v    = 1'b0;
        en      = 1'b0;
        kill    = 1'b0;
        dc_rdy  = 1'b0;
        rsp     = 1'b0;
        cpu_req = '0;
        cpu_req.data_rs1 = CPU_ADDR;
        pf_req  = '0;
        pf_req.rd       = PF_RD;
        pf_req.data_rs1 = PF_ADDR;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero(-1);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            cpu_v      = vecs[i].cpu_v;
            cpu_req.rd = vecs[i].cpu_rd;
            pf_v       = vecs[i].pf_v;
            en         = vecs[i].en;
            kill       = vecs[i].kill;
            dc_rdy     = vecs[i].rdy;
            rsp        = vecs[i].rsp;
            #7;
            check("cpu_ready", i, 64'(cpu_ready), 64'(vecs[i].e_cpu_rdy));
            check("pf_read",   i, 64'(pf_read),   64'(vecs[i].e_pf_read));
            check("pf_flush",  i, 64'(pf_flush),  64'(vecs[i].e_flush));
            check("dc_valid",  i, 64'(dc_v),      64'(vecs[i].e_dc_v));
            check("credits",   i, 64'(credits),   64'(vecs[i].e_cr));
            check("pf_lock",   i, 64'(pf_lock),   64'(vecs[i].e_lock));
            if (vecs[i].e_dc_v) begin
                check("dc_rd",    i, 64'(dc_req.rd), 64'(vecs[i].e_rd));
                check("dc_is_pf", i, 64'(dc_is_pf),  64'(vecs[i].e_is_pf));
                check("dc_addr",  i, dc_req.data_rs1,
                      vecs[i].e_is_pf ? PF_ADDR : CPU_ADDR);
            end
        end

        // Reset asserted while a demand is held in the output register
        @(posedge clk);
        #1;
        en = 1'b1; cpu_v = 1'b1; cpu_req.rd = 5'd6; pf_v = 1'b0;
        dc_rdy = 1'b0; kill = 1'b0; rsp = 1'b0;
        #7;
        check("hold cpu_ready", 100, 64'(cpu_ready), 64'd1);
        @(posedge clk);
        #1;
        check("hold dc_valid", 101, 64'(dc_v),      64'd1);
        check("hold dc_rd",    101, 64'(dc_req.rd), 64'd6);
        check("hold pf_lock",  101, 64'(pf_lock),   64'd1);
        check("hold credits",  101, 64'(credits),   64'd1);
        rst_n = 1'b0;
        kill  = 1'b1;
        #1;
        check_all_zero(102);
        @(posedge clk);
        #1;
        rst_n = 1'b1; kill = 1'b0; cpu_v = 1'b0; en = 1'b0;
        #7;
        check("post dc_valid",  103, 64'(dc_v),      64'd0);
        check("post credits",   103, 64'(credits),   64'd0);
        check("post cpu_ready", 103, 64'(cpu_ready), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hwpf_issue_arbiter
`default_nettype wire
